// File: rtl/sysid_regfile.sv
// rtl/sysid_regfile.sv - system ID / build info / uptime register file with fixed-latency pipelined reads
module sysid_regfile #(
    parameter logic [31:0] ID_VALUE     = 32'h0,
    parameter logic [31:0] TIMESTAMP    = 32'h0,
    parameter int          INFO_WORDS   = 4,
    parameter logic [((INFO_WORDS > 0) ? INFO_WORDS : 1)*32-1:0] INFO_INIT = '0,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [3:0] INFO_N = 4'(INFO_WORDS);

    logic [63:0] uptime;
    logic [31:0] scratch;
    logic [31:0] hi_shadow;
    logic        wrap;

    logic        wr_ctrl;
    logic        clr;
    logic        wrap_clr;
    logic        wrap_evt;
    logic [31:0] rd_mux;
    logic [31:0] info_mem [8];

    logic [READ_LATENCY-1:0] vld;
    logic [31:0]             dat [READ_LATENCY];

    // Unpopulated info slots read as zero, so the mux never indexes past INFO_INIT.
    for (genvar k = 0; k < 8; k++) begin : g_info
        if (k < INFO_WORDS) begin : g_used
            assign info_mem[k] = INFO_INIT[k*32 +: 32];
        end else begin : g_empty
            assign info_mem[k] = 32'h0;
        end
    end

    assign wr_ctrl  = write && (address == 4'd5) && byteenable[0];
    assign clr      = wr_ctrl && writedata[0];
    assign wrap_clr = wr_ctrl && writedata[1];
    assign wrap_evt = !clr && (uptime == 64'hFFFF_FFFF_FFFF_FFFF);

    always_comb begin
        rd_mux = 32'h0;
        case (address)
            4'd0:    rd_mux = ID_VALUE;
            4'd1:    rd_mux = TIMESTAMP;
            4'd2:    rd_mux = scratch;
            4'd3:    rd_mux = uptime[31:0];
            4'd4:    rd_mux = hi_shadow;
            4'd5:    rd_mux = {20'h0, INFO_N, 6'h0, wrap, 1'b0};
            4'd6,
            4'd7:    rd_mux = 32'h0;
            default: rd_mux = info_mem[address[2:0]];
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            uptime    <= 64'h0;
            scratch   <= 32'h0;
            hi_shadow <= 32'h0;
            wrap      <= 1'b0;
        end else begin
            uptime <= clr ? 64'h0 : uptime + 64'd1;
            if (wrap_evt) begin
                wrap <= 1'b1;
            end else if (wrap_clr) begin
                wrap <= 1'b0;
            end
            for (int b = 0; b < 4; b++) begin
                if (write && (address == 4'd2) && byteenable[b]) begin
                    scratch[b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
            // Shadow comes from the same sample as the LO word returned this cycle.
            if (read && (address == 4'd3)) begin
                hi_shadow <= uptime[63:32];
            end
        end
    end

    // Invalid stages carry zero data so readdata is zero whenever not valid.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat[i] <= 32'h0;
            end
        end else begin
            vld[0] <= read;
            dat[0] <= read ? rd_mux : 32'h0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign readdata      = dat[READ_LATENCY-1];
    assign readdatavalid = vld[READ_LATENCY-1];

endmodule
